// File: rtl/traffic_phase_sequencer.sv
// Timed phase sequencer for a 4-way junction: CLEAR / RUN / FORCE with tick-based timing.
// Optional demand-based phase skipping is enabled by defining TLC_DEMAND_SKIP_EN.
module traffic_phase_sequencer #(
  parameter int unsigned CLK_PER_TICK = 1000,
  parameter int unsigned PHASE_TICKS  = 20,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hold_i,
  input  logic       force_red_i,
  input  logic [3:0] req_i,
  output logic [1:0] state_o,
  output logic       lamp_en_o,
  output logic       phase_start_o
);

  localparam logic [CNT_W-1:0] PrescLast  = CNT_W'(CLK_PER_TICK - 1);
  localparam logic [CNT_W-1:0] PhaseLast  = CNT_W'(PHASE_TICKS - 1);
  localparam logic [CNT_W-1:0] AllredLast = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [1:0] {StClear, StRun, StForce} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       next_phase_q, next_phase_d;
  logic [1:0]       adv_phase;
  logic             lamp_en_q, lamp_en_d;
  logic             phase_start_q, phase_start_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             tick;
  logic             timer_zero;

  assign tick       = (presc_q == PrescLast);
  assign timer_zero = (timer_q == '0);

`ifdef TLC_DEMAND_SKIP_EN
  logic [1:0] cand;

  // Scan farthest-first so the nearest requesting phase (state+1 first, state last) wins.
  always_comb begin
    adv_phase = state_q + 2'd1;
    cand      = state_q;
    for (int k = 4; k >= 1; k--) begin
      cand = state_q + 2'(k);
      if (req_i[cand]) begin
        adv_phase = cand;
      end
    end
  end
`else
  logic unused_req;

  assign unused_req = ^req_i;
  assign adv_phase  = state_q + 2'd1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q         <= StClear;
      state_q       <= 2'b00;
      next_phase_q  <= 2'b00;
      lamp_en_q     <= 1'b0;
      phase_start_q <= 1'b0;
      presc_q       <= '0;
      timer_q       <= AllredLast;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      next_phase_q  <= next_phase_d;
      lamp_en_q     <= lamp_en_d;
      phase_start_q <= phase_start_d;
      presc_q       <= presc_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    next_phase_d = next_phase_q;
    presc_d      = presc_q;
    timer_d      = timer_q;
    unique case (fsm_q)
      StClear: begin
        if (force_red_i) begin
          fsm_d   = StForce;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (timer_zero) begin
            fsm_d   = StRun;
            state_d = next_phase_q;
            timer_d = PhaseLast;
          end else begin
            timer_d = timer_q - CntOne;
          end
        end else begin
          presc_d = presc_q + CntOne;
        end
      end
      StRun: begin
        // Expiry outranks hold, so a hold on the final clk does not extend the phase.
        if (force_red_i) begin
          fsm_d        = StForce;
          presc_d      = '0;
          next_phase_d = adv_phase;
        end else if (tick && timer_zero) begin
          fsm_d        = StClear;
          presc_d      = '0;
          timer_d      = AllredLast;
          next_phase_d = adv_phase;
        end else if (!hold_i) begin
          if (tick) begin
            presc_d = '0;
            timer_d = timer_q - CntOne;
          end else begin
            presc_d = presc_q + CntOne;
          end
        end
      end
      StForce: begin
        if (!force_red_i) begin
          fsm_d   = StClear;
          presc_d = '0;
          timer_d = AllredLast;
        end
      end
      default: begin
        fsm_d   = StClear;
        presc_d = '0;
        timer_d = AllredLast;
      end
    endcase
  end

  always_comb begin
    lamp_en_d     = (fsm_d == StRun);
    phase_start_d = (fsm_q == StClear) && (fsm_d == StRun);
  end

  assign state_o       = state_q;
  assign lamp_en_o     = lamp_en_q;
  assign phase_start_o = phase_start_q;

endmodule
